uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer, mid-bit
// sampling and back-to-back frame support.
// Optional build macro UART_RX_MAJORITY_EN: each bit is sampled at
// HALF-1, HALF and HALF+1. The 2-of-3 majority is decided at HALF+1,
// so rx_done and frame_err fire one cycle later than in the default
// single-sample build.
module uart_rx #(
    parameter int BAUD_DIV = 5208,
    parameter int HALF     = BAUD_DIV / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_rx,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(BAUD_DIV - 1);
    localparam logic [15:0] HALF_C  = 16'(HALF);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        done_q, done_d;
    logic        ferr_q, ferr_d;
    logic        sync1_q, sync2_q, prev_q;

    logic        fall_c;
    logic        wrap_c;
    logic        decide_c;
    logic        sample_c;

    // A start edge is a high-to-low step between consecutive synchronized samples.
    assign fall_c = prev_q & ~sync2_q;
    assign wrap_c = (cnt_q == CNT_MAX);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [15:0] HALF_M1 = 16'(HALF - 1);
    localparam logic [15:0] HALF_P1 = 16'(HALF + 1);

    logic [1:0] maj_q, maj_d;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Capture the two early samples; the third is the live value at HALF+1.
    always_comb begin
        maj_d = maj_q;
        if (cnt_q == HALF_M1) maj_d[0] = sync2_q;
        if (cnt_q == HALF_C)  maj_d[1] = sync2_q;
    end

    // Early-sample holding register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) maj_q <= 2'b11;
        else      maj_q <= maj_d;
    end

    assign decide_c = (cnt_q == HALF_P1);
    assign sample_c = majority3(maj_q[0], maj_q[1], sync2_q);
`else
    assign decide_c = (cnt_q == HALF_C);
    assign sample_c = sync2_q;
`endif

    // Two-flop synchronizer plus one delayed copy for edge detection; idle-high on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= data_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Next-state and datapath decisions for the receive FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 16'd0;
                idx_d = 3'd0;
                if (fall_c) state_d = START;
            end
            START: begin
                cnt_d = wrap_c ? 16'd0 : cnt_q + 16'd1;
                if (decide_c && sample_c) begin
                    // Start bit was a glitch: drop back without any pulse.
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (wrap_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = wrap_c ? 16'd0 : cnt_q + 16'd1;
                if (decide_c) shift_d[idx_q] = sample_c;
                if (wrap_c) begin
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                cnt_d = wrap_c ? 16'd0 : cnt_q + 16'd1;
                if (decide_c) begin
                    if (sample_c) begin
                        data_d = shift_q;
                        done_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    // Leave mid stop bit so a directly following start edge is caught.
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // FSM, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx (BAUD_DIV=16, HALF=8) with a frame-level reference model.
module tb_uart_rx;

    localparam int BD = 16;
    localparam int HF = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Line driven low just after posedge c0 -> two synchronizer stages,
    // one cycle to enter START, 9 full bit periods + HALF to the stop
    // decision, one cycle for the registered pulse.
    localparam int LAT = 3 + 9 * BD + HF + 1 + MAJ;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       data_rx = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int both_cnt = 0;
    int wide_cnt = 0;
    logic done_prev = 1'b0;
    logic ferr_prev = 1'b0;

    int         ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];

    uart_rx #(.BAUD_DIV(BD), .HALF(HF)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_rx   (data_rx),
        .data_out  (data_out),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Event recorder: kind 1 = rx_done, kind 2 = frame_err.
    always @(negedge clk) begin
        if (rx_done && frame_err) both_cnt++;
        if (rx_done && done_prev) wide_cnt++;
        if (frame_err && ferr_prev) wide_cnt++;
        if (rx_done) begin
            ev_kind.push_back(1); ev_data.push_back(data_out); ev_cyc.push_back(cyc);
        end
        if (frame_err) begin
            ev_kind.push_back(2); ev_data.push_back(data_out); ev_cyc.push_back(cyc);
        end
        done_prev = rx_done;
        ferr_prev = frame_err;
    end

    task automatic clear_events();
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // Drive one 8N1 frame; frame bit glitch_f (0=start, 1..8=data, 9=stop) is
    // inverted for the single cycle that feeds the centre sample, -1 = none.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_f);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < BD; k++) begin
                data_rx = (f == glitch_f && k == HF + 1) ? ~bits[f] : bits[f];
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        data_rx = 1'b1;
        idle_cycles(3);
        checks++; if (data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
        checks++; if (rx_done !== 1'b0) begin failures++; $display("FAIL reset_rx_done got=%b exp=0", rx_done); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL reset_rx_busy got=%b exp=0", rx_busy); end
        rst = 1'b1;
        idle_cycles(4);
    endtask

    task automatic test_single_a5();
        int c0;
        clear_events();
        c0 = cyc;
        send_frame(8'hA5, 1'b1, -1);
        idle_cycles(10);
        checks++; if (ev_kind.size() !== 1) begin failures++; $display("FAIL a5_event_count got=%0d exp=1", ev_kind.size()); end
        if (ev_kind.size() >= 1) begin
            checks++; if (ev_kind[0] !== 1) begin failures++; $display("FAIL a5_kind got=%0d exp=1", ev_kind[0]); end
            checks++; if (ev_data[0] !== 8'hA5) begin failures++; $display("FAIL a5_data got=%h exp=a5", ev_data[0]); end
            checks++; if (ev_cyc[0] - c0 !== LAT) begin failures++; $display("FAIL a5_latency got=%0d exp=%0d", ev_cyc[0] - c0, LAT); end
        end
        checks++; if (data_out !== 8'hA5) begin failures++; $display("FAIL a5_hold got=%h exp=a5", data_out); end
    endtask

    task automatic test_glitch_start(input logic [7:0] prior);
        clear_events();
        data_rx = 1'b0;
        idle_cycles(3);
        data_rx = 1'b1;
        idle_cycles(6);
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_seen got=%b exp=1", rx_busy); end
        idle_cycles(2 * BD);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL glitch_back_idle got=%b exp=0", rx_busy); end
        checks++; if (ev_kind.size() !== 0) begin failures++; $display("FAIL glitch_events got=%0d exp=0", ev_kind.size()); end
        checks++; if (data_out !== prior) begin failures++; $display("FAIL glitch_data got=%h exp=%h", data_out, prior); end
    endtask

    task automatic test_frame_err(input logic [7:0] prior);
        clear_events();
        send_frame(8'h3C, 1'b0, -1);
        // Keep the line low well past the stop bit: no new frame may start.
        data_rx = 1'b0;
        idle_cycles(3 * BD);
        checks++; if (rx_busy !== 1'b0) begin failures++; $display("FAIL ferr_low_line_busy got=%b exp=0", rx_busy); end
        data_rx = 1'b1;
        idle_cycles(10);
        checks++; if (ev_kind.size() !== 1) begin failures++; $display("FAIL ferr_event_count got=%0d exp=1", ev_kind.size()); end
        if (ev_kind.size() >= 1) begin
            checks++; if (ev_kind[0] !== 2) begin failures++; $display("FAIL ferr_kind got=%0d exp=2", ev_kind[0]); end
        end
        checks++; if (data_out !== prior) begin failures++; $display("FAIL ferr_data got=%h exp=%h", data_out, prior); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        int n;
        clear_events();
        exp_q.push_back(8'h55);
        exp_q.push_back(8'h0F);
        n = 2 + $urandom_range(2, 4);
        for (int i = 2; i < n; i++) exp_q.push_back(8'($urandom));
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, -1);
        idle_cycles(10);
        checks++; if (ev_kind.size() !== n) begin failures++; $display("FAIL b2b_event_count got=%0d exp=%0d", ev_kind.size(), n); end
        for (int i = 0; i < n && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== 1 || ev_data[i] !== exp_q[i]) begin
                failures++; $display("FAIL b2b_frame%0d got=kind%0d/%h exp=kind1/%h", i, ev_kind[i], ev_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        clear_events();
        bits = {1'b1, 8'hFF, 1'b0};
        // Start a 0xFF frame and stop part way through the data bits.
        for (int f = 0; f < 5; f++) begin
            data_rx = bits[f];
            idle_cycles(BD);
        end
        checks++; if (rx_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", rx_busy); end
        #3 rst = 1'b0;
        #1;
        checks++; if (rx_busy !== 1'b0 || data_out !== 8'h00 || rx_done !== 1'b0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL rstmid_async_outputs got=%b/%h/%b/%b exp=0/00/0/0", rx_busy, data_out, rx_done, frame_err);
        end
        data_rx = 1'b1;
        @(posedge clk); #1;
        idle_cycles(3);
        rst = 1'b1;
        idle_cycles(12 * BD);
        checks++; if (ev_kind.size() !== 0) begin failures++; $display("FAIL rstmid_aborted_events got=%0d exp=0", ev_kind.size()); end
        send_frame(8'h81, 1'b1, -1);
        idle_cycles(10);
        checks++; if (ev_kind.size() !== 1) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=1", ev_kind.size()); end
        checks++; if (data_out !== 8'h81) begin failures++; $display("FAIL rstmid_after_data got=%h exp=81", data_out); end
    endtask

    task automatic test_bit_glitch();
        logic [7:0] exp_b;
        clear_events();
`ifdef UART_RX_MAJORITY_EN
        exp_b = 8'h00;
`else
        exp_b = 8'h08;
`endif
        send_frame(8'h00, 1'b1, 4);
        idle_cycles(10);
        checks++; if (data_out !== exp_b) begin failures++; $display("FAIL bitglitch_data got=%h exp=%h", data_out, exp_b); end
    endtask

    task automatic test_random();
        int exp_kind[$];
        logic [7:0] exp_data[$];
        logic [7:0] last_good;
        logic [7:0] b;
        logic stop;
        last_good = data_out;
        clear_events();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop, -1);
            if (stop) begin
                exp_kind.push_back(1); exp_data.push_back(b); last_good = b;
            end else begin
                exp_kind.push_back(2); exp_data.push_back(last_good);
            end
            // A low stop bit needs the line to return high before the next edge.
            data_rx = 1'b1;
            idle_cycles(stop ? $urandom_range(0, 5) : $urandom_range(3, 6));
        end
        idle_cycles(10);
        checks++; if (ev_kind.size() !== exp_kind.size()) begin failures++; $display("FAIL rand_event_count got=%0d exp=%0d", ev_kind.size(), exp_kind.size()); end
        for (int i = 0; i < exp_kind.size() && i < ev_kind.size(); i++) begin
            checks++;
            if (ev_kind[i] !== exp_kind[i] || ev_data[i] !== exp_data[i]) begin
                failures++; $display("FAIL rand_frame%0d got=kind%0d/%h exp=kind%0d/%h", i, ev_kind[i], ev_data[i], exp_kind[i], exp_data[i]);
            end
        end
        checks++; if (data_out !== last_good) begin failures++; $display("FAIL rand_final_data got=%h exp=%h", data_out, last_good); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (both_cnt !== 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=0", both_cnt); end
        checks++; if (wide_cnt !== 0) begin failures++; $display("FAIL pulse_width got=%0d exp=0", wide_cnt); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_single_a5();
        test_glitch_start(8'hA5);
        test_frame_err(8'hA5);
        test_back_to_back();
        test_reset_mid();
        test_bit_glitch();
        test_random();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
